stopwatch_time_counter: RTL

- Upstream time-base stage of the stop watch. Produces the six BCD digits (MM:SS.cc) that the segment display stage multiplexes onto the 7-segment digits.
- Contains two parts:
  - a prescaler that divides the 50 MHz system clock down to a 100 Hz count tick;
  - a Moore FSM (IDLE/RUN/PAUSE) driven by start/stop and clear buttons, feeding a cascaded BCD counter.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/bcd_digit_counter.sv | 28 ++
 rtl/stopwatch_time_counter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, BCD digit limits and
// default clock/tick rates, also used by the segment display stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] DIG_MAX_9 = 4'd9;
    localparam logic [3:0] DIG_MAX_5 = 4'd5;

    localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;
    localparam int TICK_HZ_DEFAULT     = 100;

    function automatic logic is_press(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch cascade: counts 0..MAX on i_inc and
// raises o_carry combinationally in the cycle it rolls over.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIG_MAX_9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] digit,
    output logic       o_carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (i_clr) begin
            digit <= '0;
        end else if (i_inc) begin
            digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
        end
    end

    assign o_carry = i_inc & (digit == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: prescaler to a 100 Hz tick, IDLE/RUN/PAUSE control FSM
// and a six-digit BCD cascade (MM:SS.cc). Optional lap hold: STOPWATCH_LAP_EN.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int TICK_HZ     = TICK_HZ_DEFAULT,
    parameter int PRESCALE    = CLK_FREQ_HZ / TICK_HZ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start_stop,
    input  logic       i_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       i_lap,
    output logic       o_lap_active,
`endif
    output logic [3:0] t_ms0,
    output logic [3:0] t_ms1,
    output logic [3:0] t_s0,
    output logic [3:0] t_s1,
    output logic [3:0] t_m0,
    output logic [3:0] t_m1,
    output logic       o_running,
    output logic       o_wrap
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    state_t          state_q;
    state_t          state_d;
    logic            ss_p0, ss_p1;
    logic            clr_p0, clr_p1;
    logic            ss_press, clr_press;
    logic            run, tick, idle_entry;
    logic [PW-1:0]   presc_q;
    logic            wrap_q;
    logic [3:0]      ms0_q, ms1_q, s0_q, s1_q, m0_q, m1_q;
    logic            c_ms0, c_ms1, c_s0, c_s1, c_m0, c_m1;
    logic [23:0]     live, shown;

    // Stage p0/p1: button registers; a press is the rising edge between them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_p0  <= 1'b0;
            ss_p1  <= 1'b0;
            clr_p0 <= 1'b0;
            clr_p1 <= 1'b0;
        end else begin
            ss_p0  <= i_start_stop;
            ss_p1  <= ss_p0;
            clr_p0 <= i_clear;
            clr_p1 <= clr_p0;
        end
    end

    assign ss_press  = is_press(ss_p0, ss_p1);
    assign clr_press = is_press(clr_p0, clr_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear beats start/stop when both presses land together in PAUSE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_press) state_d = ST_RUN;
            ST_RUN:   if (ss_press) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clr_press)     state_d = ST_IDLE;
                else if (ss_press) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign run        = (state_q == ST_RUN);
    assign tick       = run && (presc_q == PRESC_LAST);
    assign idle_entry = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign o_running  = run;

    // Prescaler holds in PAUSE so a resumed run finishes the partial tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (idle_entry) begin
            presc_q <= '0;
        end else if (run) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_ms0 (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(tick),  .digit(ms0_q), .o_carry(c_ms0));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_ms1 (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(c_ms0), .digit(ms1_q), .o_carry(c_ms1));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_s0  (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(c_ms1), .digit(s0_q),  .o_carry(c_s0));
    bcd_digit_counter #(.MAX(DIG_MAX_5)) u_s1  (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(c_s0),  .digit(s1_q),  .o_carry(c_s1));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_m0  (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(c_s1),  .digit(m0_q),  .o_carry(c_m0));
    bcd_digit_counter #(.MAX(DIG_MAX_5)) u_m1  (.clk(clk), .rst_n(rst_n), .i_clr(idle_entry), .i_inc(c_m0),  .digit(m1_q),  .o_carry(c_m1));

    // Carry out of the top digit is the 59:59.99 -> 00:00.00 rollover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= c_m1;
        end
    end

    assign o_wrap = wrap_q;
    assign live   = {m1_q, m0_q, s1_q, s0_q, ms1_q, ms0_q};

`ifdef STOPWATCH_LAP_EN
    logic        lap_p0, lap_p1, lap_press;
    logic        lap_q;
    logic [23:0] snap_q;

    assign lap_press = is_press(lap_p0, lap_p1);

    // Lap mode only lives in RUN; leaving RUN drops back to live digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_p0 <= 1'b0;
            lap_p1 <= 1'b0;
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            lap_p0 <= i_lap;
            lap_p1 <= lap_p0;
            if (state_d != ST_RUN) begin
                lap_q <= 1'b0;
            end else if (lap_press && run) begin
                lap_q <= ~lap_q;
            end
            if (lap_press && run && !lap_q) begin
                snap_q <= live;
            end
        end
    end

    assign o_lap_active = lap_q;
    assign shown        = lap_q ? snap_q : live;
`else
    assign shown        = live;
`endif

    assign {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0} = shown;

endmodule
